// File: rtl/uart_rx_fifo_if.sv
// Bundle between a UART receiver, the RX FIFO and the bus side that drains it.
// The FIFO binds to the slave modport; the producer/consumer side uses master.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          rx_dv_i;
  logic [7:0]    rx_byte_i;
  logic          rd_en_i;
  logic [7:0]    rdata_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   level_o;
  logic [AW:0]   watermark_i;
  logic          wm_irq_o;
  logic          ovf_o;
  logic          ovf_clr_i;
  logic          fifo_clr_i;
  logic [15:0]   timeout_i;
  logic          to_irq_o;

  modport master (
    output rx_dv_i, rx_byte_i, rd_en_i, watermark_i, ovf_clr_i, fifo_clr_i, timeout_i,
    input  rdata_o, empty_o, full_o, level_o, wm_irq_o, ovf_o, to_irq_o
  );

  modport slave (
    input  rx_dv_i, rx_byte_i, rd_en_i, watermark_i, ovf_clr_i, fifo_clr_i, timeout_i,
    output rdata_o, empty_o, full_o, level_o, wm_irq_o, ovf_o, to_irq_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO for a UART, with watermark and
// idle-timeout interrupts and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   to_cnt_q, to_cnt_d;

  logic empty, full, flush, push_acc, pop_acc;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));

  always_comb begin
    flush    = bus.fifo_clr_i;
    pop_acc  = bus.rd_en_i && !empty && !flush;
    push_acc = bus.rx_dv_i && (!full || pop_acc) && !flush;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    to_cnt_d = to_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) begin
        mem_d[wr_ptr_q] = bus.rx_byte_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_acc && !pop_acc) begin
        level_d = level_q + (AW+1)'(1);
      end else if (pop_acc && !push_acc) begin
        level_d = level_q - (AW+1)'(1);
      end
    end

    // A dropped byte sets the flag even if a clear arrives in the same cycle
    if (bus.rx_dv_i && full && !pop_acc && !flush) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_d = 1'b0;
    end

    // Saturating compare also clamps the count when the threshold is lowered
    if (flush || push_acc || pop_acc || empty) begin
      to_cnt_d = '0;
    end else if (to_cnt_q >= bus.timeout_i) begin
      to_cnt_d = bus.timeout_i;
    end else begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Storage is never reset; rdata is masked while empty so stale entries never leak
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.rdata_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.empty_o  = empty;
  assign bus.full_o   = full;
  assign bus.level_o  = level_q;
  assign bus.wm_irq_o = (bus.watermark_i != '0) && (level_q >= bus.watermark_i);
  assign bus.ovf_o    = ovf_q;
  assign bus.to_irq_o = (bus.timeout_i != '0) && !empty && (to_cnt_q == bus.timeout_i);
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 8, number of byte entries in the FIFO; SHALL be a power of two, 2..256.
REQ-002 Parameter: AW, log2(DEPTH), pointer width; derived from DEPTH and SHALL NOT be overridden.
REQ-003 Port: clk_i  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 Port: rst_i  in  1  reset, asynchronous and active-high.
REQ-005 Port: rx_dv_i  in  1  one-cycle strobe from the UART receiver: received byte valid.
REQ-006 Port: rx_byte_i  in  8  received byte, qualified by rx_dv_i.
REQ-007 Port: rd_en_i  in  1  pop request from the bus side.
REQ-008 Port: rdata_o  out  8  head-of-FIFO byte (first-word fall-through).
REQ-009 Port: empty_o  out  1  FIFO holds zero entries.
REQ-010 Port: full_o  out  1  FIFO holds DEPTH entries.
REQ-011 Port: level_o  out  AW+1  current entry count, 0..DEPTH.
REQ-012 Port: watermark_i  in  AW+1  interrupt threshold level.
REQ-013 Port: wm_irq_o  out  1  level at or above the watermark.
REQ-014 Port: ovf_o  out  1  sticky overflow flag.
REQ-015 Port: ovf_clr_i  in  1  clears ovf_o.
REQ-016 Port: fifo_clr_i  in  1  synchronous flush.
REQ-017 Port: timeout_i  in  16  idle-timeout threshold in clk_i cycles; 0 disables the timeout.
REQ-018 Port: to_irq_o  out  1  receive idle-timeout indication.

Function
REQ-019 Storage: DEPTH x 8 register array; write pointer and read pointer are AW bits wide and wrap from DEPTH-1 to 0.
REQ-020 Pop: accepted when rd_en_i=1 and empty_o=0; rd_en_i while empty is ignored, with no state change.
REQ-021 Push: accepted when rx_dv_i=1 and (full_o=0 or a pop is accepted in the same cycle).
REQ-022 Push when full with no pop: the byte is dropped, FIFO contents are unchanged, and ovf_o=1 from the next cycle.
REQ-023 Level update per cycle:
- push only: level +1
- pop only: level -1
- push and pop together: level unchanged
- neither: level unchanged
REQ-024 Flags: empty_o = (level==0); full_o = (level==DEPTH); both are derived from registered state only.
REQ-025 rdata_o = array[read pointer] when not empty, and 8'h00 when empty.
REQ-026 Push latency: a byte pushed in cycle N appears on rdata_o (if it is at the head) and in level_o in cycle N+1.
REQ-027 wm_irq_o = (watermark_i != 0) and (level_o >= watermark_i); it is a level signal, not a pulse.
REQ-028 ovf_o: set by REQ-022 and cleared by ovf_clr_i; if both occur in the same cycle, set wins.
REQ-029 Flush (fifo_clr_i=1): next cycle pointers=0, level=0, timeout counter=0.
- A push or pop in the same cycle is discarded.
- ovf_o is unaffected by flush.
REQ-030 Timeout counter: 16 bits, cleared on any accepted push, accepted pop, flush, or while empty.
- Otherwise it increments by 1 per cycle, saturating at timeout_i.
REQ-031 to_irq_o = (timeout_i != 0) and (empty_o = 0) and (counter == timeout_i).
- It deasserts the cycle after the next push, pop, or flush.
REQ-032 If timeout_i is lowered below the current count, the counter SHALL be clamped to timeout_i on the next cycle and to_irq_o asserts.

Reset
REQ-033 rst_i=1 asynchronously forces:
- pointers, level and timeout counter = 0
- ovf_o=0, empty_o=1, full_o=0, wm_irq_o=0, to_irq_o=0, rdata_o=8'h00
REQ-034 Array contents need not be reset; no output SHALL depend on unwritten entries.
REQ-035 Reset asserted mid-operation discards all stored bytes; the first push after reset release is stored at entry 0.

Verification
REQ-036 Ordering: DEPTH=8; push 8'hA1, 8'hB2, 8'hC3 -> level_o=3, rdata_o=8'hA1; three pops -> 8'hA1, 8'hB2, 8'hC3 in order, then empty_o=1, rdata_o=8'h00.
REQ-037 Overflow: push 9 bytes 8'h00..8'h08 with no pops -> full_o=1 after the 8th push, 9th byte dropped, ovf_o=1; pops return 8'h00..8'h07; ovf_clr_i -> ovf_o=0.
REQ-038 Simultaneous push and pop:
- When full, push 8'h55 with a pop -> level stays 8, the popped byte is the oldest, and 8'h55 is the last byte out, ovf_o=0.
- When empty, rd_en_i together with a push -> the push is stored and level=1.
REQ-039 Watermark and wrap: watermark_i=4; run 20 push/pop cycles crossing the pointer wrap -> wm_irq_o=1 exactly while level>=4; watermark_i=0 -> wm_irq_o=0.
REQ-040 Timeout: timeout_i=100; push one byte and then go idle -> to_irq_o rises exactly 100 cycles after the push; a pop clears it; with timeout_i=0, to_irq_o never asserts.
REQ-041 Flush/reset: with 5 entries and ovf_o=1, assert fifo_clr_i together with rx_dv_i -> next cycle level=0 and ovf_o=1; then assert rst_i mid-stream -> all REQ-033 values appear immediately.
